// File: rtl/adc_cap_pkg.sv
// Shared widths and types for the ADC capture controller.
package adc_cap_pkg;
  localparam int ADC_DATA_W = 11;
  localparam int ADC_TRIM_W = 3;

  typedef logic [ADC_DATA_W-1:0] adc_sample_t;
  typedef logic [ADC_TRIM_W-1:0] adc_trim_t;
endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Sample stream from the capture FIFO to the lab/test logic (valid/ready).
interface adc_capture_ctrl_if
  import adc_cap_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W
);
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready;

  modport master (output sample_data, sample_valid, input sample_ready);
  modport slave  (input sample_data, sample_valid, output sample_ready);
endinterface

// File: rtl/adc_cap_fifo.sv
// First-word-fall-through sample buffer; DEPTH must be a power of 2 (>= 2).
module adc_cap_fifo
  import adc_cap_pkg::*;
#(
  parameter  int W     = ADC_DATA_W,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);
  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wr_q, rd_q;
  logic [LW-1:0]           lvl_q;
  logic                    pop_ok, push_ok;

  assign empty_o = (lvl_q == '0);
  assign full_o  = (lvl_q == LW'(DEPTH));
  assign pop_ok  = pop_i & ~empty_o;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign push_ok = push_i & (~full_o | pop_ok);
  assign dout_o  = mem_q[rd_q];
  assign level_o = lvl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_ok) rd_q <= rd_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   lvl_q <= lvl_q + LW'(1);
        2'b01:   lvl_q <= lvl_q - LW'(1);
        default: lvl_q <= lvl_q;
      endcase
    end
  end
endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC conversion clock generator, trim driver and sample capture into a FWFT buffer.
module adc_capture_ctrl
  import adc_cap_pkg::*;
#(
  parameter  int DATA_W     = ADC_DATA_W,
  parameter  int TRIM_W     = ADC_TRIM_W,
  parameter  int DIV_W      = 8,
  parameter  int FIFO_DEPTH = 8,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div_ratio,
  input  logic [DIV_W-1:0]  capture_dly,
  input  logic [TRIM_W-1:0] trim_in,
  input  logic              trim_load,
  input  logic [DATA_W-1:0] adc_bits,
  output logic              clk_adc,
  output logic [TRIM_W-1:0] trm_adc,
  adc_capture_ctrl_if.master smp,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow,
  input  logic              clear_ovf
);
  logic [DIV_W-1:0]  cnt_q, cnt_d, dper_q, dper_d, dly_q, dly_d, div_eff;
  logic              clk_adc_q, clk_adc_d, run_q, arm_q, arm_d, rise;
  logic [DATA_W-1:0] sync1_q, sync_q, fifo_dout;
  logic [TRIM_W-1:0] trm_q, trm_d, pend_q, pend_d;
  logic              pend_v_q, pend_v_d, apply;
  logic              ovf_q, ovf_d, cap, pop, drop, fifo_full, fifo_empty;

  assign div_eff = (div_ratio == '0) ? DIV_W'(1) : div_ratio;

  // A started high phase always runs to completion; low phases only count
  // while enabled, and the first enabled cycle just arms the divider.
  always_comb begin
    clk_adc_d = clk_adc_q;
    cnt_d     = cnt_q;
    dper_d    = dper_q;
    rise      = 1'b0;
    if (clk_adc_q || (enable && run_q)) begin
      if (cnt_q == dper_q - DIV_W'(1)) begin
        clk_adc_d = ~clk_adc_q;
        cnt_d     = '0;
        dper_d    = div_eff;
        rise      = ~clk_adc_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end else begin
      cnt_d  = '0;
      dper_d = div_eff;
    end
  end

  // One capture per period: arm on the rise, disarm on capture or disable.
  always_comb begin
    cap   = arm_q & enable & (dly_q == capture_dly);
    dly_d = rise ? '0 : ((&dly_q) ? dly_q : dly_q + DIV_W'(1));
    arm_d = arm_q;
    if (!enable)  arm_d = 1'b0;
    else if (rise) arm_d = 1'b1;
    else if (cap)  arm_d = 1'b0;
  end

  always_comb begin
    apply    = pend_v_q & ~clk_adc_q;
    trm_d    = apply ? pend_q : trm_q;
    pend_d   = trim_load ? trim_in : pend_q;
    pend_v_d = trim_load | (pend_v_q & ~apply);
  end

  assign pop  = smp.sample_valid & smp.sample_ready;
  assign drop = cap & fifo_full & ~pop;

  always_comb begin
    ovf_d = ovf_q;
    if (drop)           ovf_d = 1'b1;
    else if (clear_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      dper_q    <= DIV_W'(1);
      dly_q     <= '0;
      clk_adc_q <= 1'b0;
      run_q     <= 1'b0;
      arm_q     <= 1'b0;
      sync1_q   <= '0;
      sync_q    <= '0;
      trm_q     <= '0;
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dper_q    <= dper_d;
      dly_q     <= dly_d;
      clk_adc_q <= clk_adc_d;
      run_q     <= enable;
      arm_q     <= arm_d;
      sync1_q   <= adc_bits;
      sync_q    <= sync1_q;
      trm_q     <= trm_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      ovf_q     <= ovf_d;
    end
  end

  adc_cap_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cap),
    .din_i   (sync_q),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign smp.sample_data  = fifo_dout;
  assign smp.sample_valid = ~fifo_empty;
  assign clk_adc          = clk_adc_q;
  assign trm_adc          = trm_q;
  assign overflow         = ovf_q;
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Randomized bench: timing model derived from edge arithmetic, samples scoreboarded.
module tb_adc_capture_ctrl;
  import adc_cap_pkg::*;
  localparam int DEPTH = 8;

  logic        clk = 0, rst_n = 0, enable = 0, trim_load = 0, clear_ovf = 0;
  logic [7:0]  div_ratio = 0, capture_dly = 0;
  logic [2:0]  trim_in = 0;
  adc_sample_t adc_bits = 0;
  logic        clk_adc, overflow;
  logic [2:0]  trm_adc;
  logic [3:0]  fifo_level;

  adc_capture_ctrl_if #(.DATA_W(11)) smp();

  adc_capture_ctrl #(.DATA_W(11), .TRIM_W(3), .DIV_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .div_ratio(div_ratio),
    .capture_dly(capture_dly), .trim_in(trim_in), .trim_load(trim_load),
    .adc_bits(adc_bits), .clk_adc(clk_adc), .trm_adc(trm_adc), .smp(smp),
    .fifo_level(fifo_level), .overflow(overflow), .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: n counts edges since enable was first sampled high.
  bit          seg_on = 0, mclk = 0, mov = 0, mpend_v = 0;
  int          n = 0, nx = -1, md = 1, mcd = 0, mlev = 0;
  logic [2:0]  mtrm = 0, mpend = 0;
  adc_sample_t h0 = 0, h1 = 0, h2 = 0;
  adc_sample_t exp_q[$];

  function automatic bit phase_hi(int k);
    return k >= md && ((k - md) % (2 * md)) < md;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_on = 0; mclk = 0; mov = 0; mpend_v = 0; n = 0; nx = -1;
      mlev = 0; mtrm = 0; mpend = 0; h0 = 0; h1 = 0; h2 = 0;
      exp_q.delete();
    end else begin
      bit pop, cap, clk_now, apply;
      h2 = h1; h1 = h0; h0 = adc_bits;
      if (seg_on) begin
        n++;
        if (nx >= 0 && n > nx + 2 * md + 2) seg_on = 0;
      end
      if (!seg_on && enable) begin
        seg_on = 1; n = 0; nx = -1;
        md = (div_ratio == 0) ? 1 : int'(div_ratio);
        mcd = int'(capture_dly);
      end
      if (seg_on && nx < 0 && !enable) nx = n;
      if (!seg_on)     clk_now = 0;
      else if (nx < 0) clk_now = phase_hi(n);
      else clk_now = phase_hi(nx - 1) && phase_hi(n) &&
                     ((n - md) / (2 * md) == (nx - 1 - md) / (2 * md));
      cap = seg_on && nx < 0 && mcd < 2 * md && n >= md + mcd + 1 &&
            ((n - md - mcd - 1) % (2 * md) == 0);
      pop = (mlev > 0) && smp.sample_ready;
      if (pop) mlev--;
      if (cap && mlev == DEPTH) mov = 1;
      else begin
        if (cap) begin mlev++; exp_q.push_back(h2); end
        if (clear_ovf) mov = 0;
      end
      apply = mpend_v && !mclk;
      if (apply) mtrm = mpend;
      if (trim_load) begin mpend = trim_in; mpend_v = 1; end
      else if (apply) mpend_v = 0;
      mclk = clk_now;
    end
  end

  // Monitor: state checks every cycle, data popped from scoreboard on handshake.
  always @(negedge clk) begin
    chk("clk_adc", 32'(clk_adc), 32'(mclk));
    chk("fifo_level", 32'(fifo_level), 32'(mlev));
    chk("sample_valid", 32'(smp.sample_valid), 32'(mlev > 0));
    chk("overflow", 32'(overflow), 32'(mov));
    chk("trm_adc", 32'(trm_adc), 32'(mtrm));
    if (rst_n && smp.sample_valid && smp.sample_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sample_unexpected got=%0h want=none @%0t", smp.sample_data, $time);
      end else begin
        adc_sample_t e;
        e = exp_q.pop_front();
        chk("sample_data", 32'(smp.sample_data), 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic drive(int rdy, bit rnd_adc, bit rnd_ctl);
    smp.sample_ready = (int'($urandom_range(99)) < rdy);
    if (rnd_adc) adc_bits = adc_sample_t'($urandom);
    trim_in   = 3'($urandom);
    trim_load = rnd_ctl && ($urandom_range(11) == 0);
    clear_ovf = rnd_ctl && ($urandom_range(29) == 0);
  endtask

  task automatic run_seg(int div, int cd, int len, int rdy, bit rnd_adc, bit rnd_ctl);
    div_ratio = 8'(div); capture_dly = 8'(cd); enable = 1;
    repeat (len) begin drive(rdy, rnd_adc, rnd_ctl); tick(); end
    enable = 0;
    repeat (2 * ((div == 0) ? 1 : div) + 6) begin drive(rdy, rnd_adc, rnd_ctl); tick(); end
  endtask

  initial begin
    int pct [4] = '{0, 30, 60, 100};
    smp.sample_ready = 0;
    repeat (3) tick();
    chk("rst_data", 32'(smp.sample_data), 32'h0);
    rst_n = 1;
    tick();
    adc_bits = 11'h5A3;
    run_seg(2, 3, 40, 100, 0, 0);
    run_seg(0, 0, 20, 100, 0, 0);
    run_seg(1, 1, 60, 0, 1, 0);
    smp.sample_ready = 1; clear_ovf = 1; tick();
    clear_ovf = 0; repeat (10) tick();
    run_seg(1, 0, 30, 0, 1, 0);
    run_seg(1, 0, 200, 50, 1, 1);
    for (int i = 0; i < 25; i++)
      run_seg($urandom_range(0, 6), $urandom_range(0, 14), $urandom_range(10, 120),
              pct[$urandom_range(0, 3)], 1, 1);
    div_ratio = 1; capture_dly = 0; enable = 1; smp.sample_ready = 0;
    trim_in = 3'b110; trim_load = 1; tick();
    trim_load = 0; repeat (20) tick();
    rst_n = 0; enable = 0;
    #1;
    chk("rst_valid", 32'(smp.sample_valid), 32'h0);
    chk("rst_level", 32'(fifo_level), 32'h0);
    chk("rst_trm", 32'(trm_adc), 32'h0);
    chk("rst_clk_adc", 32'(clk_adc), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_data_mid", 32'(smp.sample_data), 32'h0);
    repeat (3) tick();
    rst_n = 1; tick();
    run_seg(3, 2, 40, 60, 1, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Digital-side counterpart of the miniasic ADC pad ring. It generates the ADC conversion clock (clk_adc) and drives the trim pins (trm0..2). It also samples the 11-bit parallel ADC output bus (out_bits10..0) coming back through the pads. Captured samples are buffered in a small FIFO and streamed to the lab/test logic over a valid/ready interface.

Parameters:
DATA_W, 11, ADC output word width (out_bits10..0).
TRIM_W, 3, trim code width (trm0..2).
DIV_W, 8, width of the clock-divider and capture-delay controls.
FIFO_DEPTH, 8, sample buffer depth; must be a power of 2, minimum 2.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
rst_n  in  1  asynchronous active-low reset.
enable  in  1  run ADC clock and capture.
div_ratio  in  DIV_W  clk_adc half-period in clk cycles; 0 is treated as 1.
capture_dly  in  DIV_W  clk cycles from clk_adc rise to capture.
trim_in  in  TRIM_W  new trim code.
trim_load  in  1  one-cycle pulse; requests a trim update.
adc_bits  in  DATA_W  ADC output bus from the pads; asynchronous to clk.
clk_adc  out  1  ADC conversion clock to the pad.
trm_adc  out  TRIM_W  trim code to the pads (bit0 = trm0).
sample_data  out  DATA_W  head-of-FIFO sample.
sample_valid  out  1  FIFO not empty.
sample_ready  in  1  consumer accepts sample_data.
fifo_level  out  $clog2(FIFO_DEPTH)+1  number of stored samples.
overflow  out  1  sticky flag: a sample was dropped.
clear_ovf  in  1  clears overflow.

Behaviour:
- Reset: clk_adc=0, trm_adc=0, sample_valid=0, sample_data=0, fifo_level=0, overflow=0. All counters, the trim-pending flag and the synchronizer flops are cleared.
- Divider: the half-period counter counts 0..D-1, where D = max(div_ratio,1). clk_adc toggles when the count reaches D-1.
  - First rise occurs D cycles after enable is first sampled high. Period is 2*D.
  - div_ratio is sampled only at counter wrap.
- Disable:
  - If enable drops while clk_adc=1, the high phase completes, then clk_adc stays 0 and the counter resets.
  - If enable drops while clk_adc=0, the clock stops immediately.
  - No rises occur while enable=0.
- Synchronizer: adc_bits passes through a 2-flop synchronizer (sync_q).
- Capture:
  - The delay counter restarts at 0 on each clk_adc rise and saturates at all-ones.
  - In the cycle where it equals capture_dly, sync_q is written to the FIFO. This is exactly one write per clk_adc period.
  - If capture_dly >= 2*D, no capture occurs in that period.
  - No capture occurs after disable.
- FIFO:
  - First-word-fall-through. A pop occurs when sample_valid && sample_ready.
  - Write to an empty FIFO: sample_valid rises the following cycle.
  - Full with a simultaneous pop: the write is accepted and fifo_level is unchanged.
  - Full without a pop: the sample is dropped, FIFO contents are untouched, and overflow is set.
  - clear_ovf clears overflow. If a drop and clear_ovf occur in the same cycle, the set wins.
  - Pointers wrap modulo FIFO_DEPTH.
- Trim:
  - On trim_load, trim_in is latched into a pending register.
  - The pending code is applied to trm_adc in the cycle after clk_adc is low. If clk_adc is already low, it is applied next cycle; if high, it is applied the cycle after the falling edge.
  - A second trim_load before application overwrites the pending code.
- Reset mid-operation: all state returns immediately to reset values, and the FIFO contents are discarded.

Decomposition:
- Shared package adc_cap_pkg:
  - constants ADC_DATA_W=11, ADC_TRIM_W=3;
  - typedefs adc_sample_t (logic[10:0]) and adc_trim_t (logic[2:0]).
- Sub-module adc_cap_fifo:
  - parameterized FWFT FIFO with push, pop, full, empty, level and dout;
  - the drop/overflow decision stays in the top level.

Test Plan:
1. rst_n=1, div_ratio=2, enable=1 at cycle 0 -> clk_adc rises at cycle 2, period 4, 50% duty; div_ratio=0 gives period 2.
2. adc_bits=11'h5A3, capture_dly=3, sample_ready=1 -> one sample 11'h5A3 per clk_adc period; sample_valid is high 4 cycles after each rise for 1 cycle.
3. sample_ready=0, adc_bits incrementing 0..9 per period -> fifo_level saturates at 8 and overflow=1. Draining yields 0..7 in order. clear_ovf -> overflow=0.
4. Full FIFO with simultaneous pop and capture -> level stays 8 and overflow stays 0.
5. trim_in=3'b101, trim_load while clk_adc=1 -> trm_adc is unchanged until the cycle after the falling edge, then becomes 101. trim_load while low -> trm_adc updates next cycle.
6. enable=0 mid high phase -> clk_adc finishes its high phase, then stays 0 with no further writes. A later rst_n pulse with a non-empty FIFO -> sample_valid=0, fifo_level=0, trm_adc=0.
